cache_write_buffer: RTL and testbench
=====================================

Name: cache_write_buffer

Overview:
- Sits between the set-associative cache and the block RAM.
- Accepts evicted 32-bit cache blocks from the cache and buffers them in a small FIFO. Drains them to RAM in the background.
- Services cache block-load requests with priority. Loads that hit a buffered block are forwarded from the buffer; misses go to RAM.
- Decouples the cache from RAM store latency.

Parameters:
- DEPTH, 4, number of buffered block entries (power of 2, ≥2).
- ADDR_W, 16, block address width.
- DATA_W, 32, cache block width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- store_req  in  1  cache requests buffering of a block; held high until store_ack.
- store_addr  in  ADDR_W  block address of the evicted block.
- store_data  in  DATA_W  evicted block.
- store_ack  out  1  one-cycle pulse: block accepted.
- load_req  in  1  cache requests a block; held high until load_done.
- load_addr  in  ADDR_W  requested block address.
- load_data  out  DATA_W  returned block, valid while load_done=1.
- load_done  out  1  one-cycle pulse: load_data valid.
- flush_req  in  1  level: drain has priority over loads until empty.
- empty  out  1  no buffered entries.
- full  out  1  count==DEPTH.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write block.
- mem_wren  out  1  RAM write enable.
- mem_load_req  out  1  RAM load request.
- mem_rdata  in  DATA_W  RAM read block (registered, address-following).
- mem_load_completed  in  1  RAM load data valid.
- mem_store_completed  in  1  RAM store done (high one cycle after wren sampled).

Behaviour:
- Reset:
  - All outputs and control signals are 0; empty=1.
  - FIFO pointers and count are cleared and entries are invalidated.
  - A reset mid-operation drops any in-flight drain or load. No ack or done is issued for it.
- Storage:
  - Circular FIFO: head/tail pointers plus count, 0..DEPTH.
  - Pointers wrap modulo DEPTH.
- Store acceptance:
  - Accepted at an edge where store_req=1, store_ack=0, and either (a) the address matches a valid entry that is not the head under drain, or (b) count<DEPTH.
  - store_ack=1 in the following cycle.
- Coalescing:
  - Case (a) overwrites the matching entry's data; count is unchanged. It is accepted even when full.
  - A match on the head while in DRAIN or DRAIN_WAIT allocates a new entry instead.
  - Allocation without a free slot stalls (no ack) until a pop.
- Pop versus allocate: a pop and an allocate in the same cycle leave count unchanged. full deasserts on the pop edge.
- FSM states: IDLE, LOAD, LOAD_RESP, DRAIN, DRAIN_WAIT.
- IDLE priority:
  - flush_req=1 or full=1 with count>0: go to DRAIN.
  - Otherwise load_req=1 and load_done=0: accept the load.
  - Otherwise count>0: go to DRAIN.
- Load accepted at edge N, hit:
  - Compare against all valid entries plus a store accepted at the same edge.
  - The matching entry's data is used; a same-edge store wins.
  - load_data and load_done=1 in cycle N+1. FSM stays in IDLE. No RAM access.
- Load accepted at edge N, miss:
  - Go to LOAD. mem_load_req=1 and mem_addr=load_addr until mem_load_completed is sampled high.
  - Capture mem_rdata into load_data and go to LOAD_RESP, with load_done=1 for one cycle. Then go to IDLE.
  - With the 1-cycle RAM, load_done is asserted in cycle N+3.
- DRAIN:
  - mem_wren=1, mem_addr/mem_wdata = head entry.
  - On mem_store_completed sampled high: pop head, mem_wren=0, go to DRAIN_WAIT.
- DRAIN_WAIT:
  - Wait for mem_store_completed=0, then go to IDLE.
  - Loads are never issued while a drain is in progress.
- Mutual exclusion: mem_wren and mem_load_req are never both 1.
- Ordering: loads return the youngest data for the address, either buffered or in RAM.

Test Plan:
- Reset then store 0x0004/0xDEAD0100 → store_ack pulses 1 cycle later. empty falls, then rises after the drain. RAM[0x0004]=0xDEAD0100. mem_wren is high for exactly 1 cycle before store_completed.
- Four stores 0x10..0x13 with drain blocked by a held load miss → full=1 after the 4th. A 5th store to 0x20 gets no ack until the first pop, then is acked.
- Store 0x28/0xBEEF0000, then immediately load 0x28 before the drain → load_done in acceptance+1 with 0xBEEF0000. mem_load_req stays 0.
- Load 0x0030 with empty buffer → mem_load_req high, load_done at acceptance+3 with data 0x00000030.
- Store 0x08/0x1 then 0x08/0x2 before the drain → count=1, a single RAM write of 0x2.
- Assert rst_n=0 mid-DRAIN → mem_wren drops immediately, empty=1, no store_ack or load_done afterwards.

Source files
------------

// File: rtl/cache_write_buffer.sv
// Write buffer between the set-associative cache and block RAM: queues evicted
// blocks in a circular FIFO, drains them in the background, forwards load hits.
module cache_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              store_req,
    input  logic [ADDR_W-1:0] store_addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              store_ack,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [DATA_W-1:0] load_data,
    output logic              load_done,
    input  logic              flush_req,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic              mem_load_req,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_load_completed,
    input  logic              mem_store_completed
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOAD_RESP,
        ST_DRAIN,
        ST_DRAIN_WAIT
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr [DEPTH];
    logic [DATA_W-1:0]   r_data [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;

    logic                r_store_ack;
    logic                r_load_done;
    logic [DATA_W-1:0]   r_load_data;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_wren;
    logic                r_mem_load_req;

    logic [PTR_W-1:0]    w_scan [DEPTH];
    logic                w_draining;
    logic                w_full;
    logic                w_has;
    logic                w_st_match;
    logic [PTR_W-1:0]    w_st_idx;
    logic                w_ld_match;
    logic [PTR_W-1:0]    w_ld_idx;
    logic                w_st_acc;
    logic                w_st_alloc;
    logic [PTR_W-1:0]    w_wr_idx;
    logic                w_pop;
    logic                w_prio_drain;
    logic                w_ld_acc;
    logic                w_ld_hit_st;
    logic                w_ld_hit;
    logic [DATA_W-1:0]   w_ld_hit_data;
    logic [DATA_W-1:0]   w_head_wdata;

    // Slots in age order, oldest (head) first, so the last match is the youngest.
    for (genvar g = 0; g < DEPTH; g++) begin : g_scan
        assign w_scan[g] = r_head + PTR_W'(g);
    end

    assign w_draining = (r_state == ST_DRAIN) || (r_state == ST_DRAIN_WAIT);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_has      = (r_count != '0);

    always_comb begin
        w_st_match = 1'b0;
        w_st_idx   = '0;
        w_ld_match = 1'b0;
        w_ld_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_valid[w_scan[k]] && (r_addr[w_scan[k]] == store_addr) &&
                !(w_draining && (k == 0))) begin
                w_st_match = 1'b1;
                w_st_idx   = w_scan[k];
            end
            if (r_valid[w_scan[k]] && (r_addr[w_scan[k]] == load_addr)) begin
                w_ld_match = 1'b1;
                w_ld_idx   = w_scan[k];
            end
        end
    end

    assign w_st_acc     = store_req && !r_store_ack && (w_st_match || !w_full);
    assign w_st_alloc   = w_st_acc && !w_st_match;
    assign w_wr_idx     = w_st_match ? w_st_idx : r_tail;
    assign w_pop        = (r_state == ST_DRAIN) && mem_store_completed;
    assign w_prio_drain = w_has && (flush_req || w_full);
    assign w_ld_acc     = (r_state == ST_IDLE) && !w_prio_drain && load_req && !r_load_done;
    assign w_ld_hit_st  = w_st_acc && (store_addr == load_addr);
    assign w_ld_hit     = w_ld_match || w_ld_hit_st;
    assign w_ld_hit_data = w_ld_hit_st ? store_data : r_data[w_ld_idx];
    // A store coalescing into the head on the drain-entry edge must reach RAM.
    assign w_head_wdata = (w_st_acc && w_st_match && (w_st_idx == r_head)) ?
                          store_data : r_data[r_head];

    always_ff @(posedge clk) begin
        if (w_st_acc) begin
            r_addr[w_wr_idx] <= store_addr;
            r_data[w_wr_idx] <= store_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_valid        <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_store_ack    <= 1'b0;
            r_load_done    <= 1'b0;
            r_load_data    <= '0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_wren     <= 1'b0;
            r_mem_load_req <= 1'b0;
        end else begin
            r_store_ack <= w_st_acc;
            r_load_done <= 1'b0;

            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_st_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_st_alloc && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_st_alloc && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_ld_acc) begin
                        if (w_ld_hit) begin
                            r_load_data <= w_ld_hit_data;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state        <= ST_LOAD;
                            r_mem_load_req <= 1'b1;
                            r_mem_addr     <= load_addr;
                        end
                    end else if (w_has) begin
                        r_state     <= ST_DRAIN;
                        r_mem_wren  <= 1'b1;
                        r_mem_addr  <= r_addr[r_head];
                        r_mem_wdata <= w_head_wdata;
                    end
                end
                ST_LOAD: begin
                    if (mem_load_completed) begin
                        r_load_data    <= mem_rdata;
                        r_load_done    <= 1'b1;
                        r_mem_load_req <= 1'b0;
                        r_state        <= ST_LOAD_RESP;
                    end
                end
                ST_LOAD_RESP: begin
                    r_state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (mem_store_completed) begin
                        r_mem_wren <= 1'b0;
                        r_state    <= ST_DRAIN_WAIT;
                    end
                end
                ST_DRAIN_WAIT: begin
                    if (!mem_store_completed) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign store_ack    = r_store_ack;
    assign load_done    = r_load_done;
    assign load_data    = r_load_data;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_wren     = r_mem_wren;
    assign mem_load_req = r_mem_load_req;
    assign empty        = !w_has;
    assign full         = w_full;

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed bench for cache_write_buffer with a one-cycle block RAM model.
module tb_cache_write_buffer;

    logic        clk;
    logic        rst_n;
    logic        store_req;
    logic [15:0] store_addr;
    logic [31:0] store_data;
    logic        store_ack;
    logic        load_req;
    logic [15:0] load_addr;
    logic [31:0] load_data;
    logic        load_done;
    logic        flush_req;
    logic        empty;
    logic        full;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wren;
    logic        mem_load_req;
    logic [31:0] mem_rdata;
    logic        mem_load_completed;
    logic        mem_store_completed;

    cache_write_buffer #(
        .DEPTH (4),
        .ADDR_W(16),
        .DATA_W(32)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .store_req          (store_req),
        .store_addr         (store_addr),
        .store_data         (store_data),
        .store_ack          (store_ack),
        .load_req           (load_req),
        .load_addr          (load_addr),
        .load_data          (load_data),
        .load_done          (load_done),
        .flush_req          (flush_req),
        .empty              (empty),
        .full               (full),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_wren           (mem_wren),
        .mem_load_req       (mem_load_req),
        .mem_rdata          (mem_rdata),
        .mem_load_completed (mem_load_completed),
        .mem_store_completed(mem_store_completed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: unwritten words read back as their own address.
    logic [31:0]  ram [256];
    logic [255:0] ram_wr;
    logic         ram_clr;
    logic         ram_stall;
    logic         wren_q;
    int           wren_rises;
    int           wren_pre;
    int           mlr_cyc;
    int           excl_cnt;

    function automatic logic [31:0] ram_rd(input logic [7:0] a);
        return ram_wr[a] ? ram[a] : {24'h0, a};
    endfunction

    always @(posedge clk) begin
        if (ram_clr) begin
            ram_wr              <= '0;
            wren_q              <= 1'b0;
            wren_rises          <= 0;
            wren_pre            <= 0;
            mlr_cyc             <= 0;
            excl_cnt            <= 0;
            mem_store_completed <= 1'b0;
            mem_load_completed  <= 1'b0;
            mem_rdata           <= '0;
        end else begin
            if (mem_wren) begin
                ram[mem_addr[7:0]]    <= mem_wdata;
                ram_wr[mem_addr[7:0]] <= 1'b1;
            end
            mem_store_completed <= mem_wren;
            mem_load_completed  <= mem_load_req && !ram_stall;
            mem_rdata           <= ram_rd(mem_addr[7:0]);
            wren_q              <= mem_wren;
            if (mem_wren && !wren_q)               wren_rises <= wren_rises + 1;
            if (mem_wren && !mem_store_completed)  wren_pre   <= wren_pre + 1;
            if (mem_load_req)                      mlr_cyc    <= mlr_cyc + 1;
            if (mem_wren && mem_load_req)          excl_cnt   <= excl_cnt + 1;
        end
    end

    int          n_checks;
    int          n_errors;
    int          cyc;
    int          ld_t0;
    int          ld_lat;
    logic        ld_seen;
    logic [31:0] ld_data;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge. A pending load
    // is retired here so load_req always drops right after load_done.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (load_req && load_done) begin
            ld_data = load_data;
            ld_lat  = cyc - ld_t0;
            ld_seen = 1'b1;
            load_req = 1'b0;
        end
    endtask

    task automatic start_load(input logic [15:0] a);
        load_addr = a;
        load_req  = 1'b1;
        ld_seen   = 1'b0;
        ld_t0     = cyc;
    endtask

    task automatic wait_load(input string tag);
        for (int i = 0; i < 40 && !ld_seen; i++) step();
        check_val({tag, "_done_seen"}, ld_seen, 1);
    endtask

    task automatic do_store(input string tag, input logic [15:0] a, input logic [31:0] d,
                            input int exp_lat);
        int lat;
        store_addr = a;
        store_data = d;
        store_req  = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            lat++;
            if (store_ack) break;
        end
        store_req = 1'b0;
        check_val({tag, "_ack_lat"}, lat, exp_lat);
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 100 && !empty; i++) step();
        check_val({tag, "_empty"}, empty, 1);
        repeat (4) step();
    endtask

    initial begin
        int   s0;
        logic acked;
        logic saw_low;
        n_checks = 0; n_errors = 0; cyc = 0; ld_t0 = 0; ld_lat = 0;
        ld_seen = 1'b0; ld_data = '0;
        rst_n = 1'b0; ram_clr = 1'b1; ram_stall = 1'b0;
        store_req = 1'b0; store_addr = '0; store_data = '0;
        load_req = 1'b0; load_addr = '0; flush_req = 1'b0;
        repeat (3) step();

        // Reset state
        check_val("rst_store_ack", store_ack, 0);
        check_val("rst_load_done", load_done, 0);
        check_val("rst_mem_wren", mem_wren, 0);
        check_val("rst_mem_load_req", mem_load_req, 0);
        check_val("rst_empty", empty, 1);
        check_val("rst_full", full, 0);
        check_val("rst_load_data", load_data, 0);
        rst_n = 1'b1; ram_clr = 1'b0;
        step();

        // Single store drains to RAM
        s0 = wren_pre;
        do_store("t1", 16'h0004, 32'hDEAD0100, 1);
        check_val("t1_empty_low", empty, 0);
        wait_empty("t1");
        check_val("t1_ram", ram_rd(8'h04), 32'hDEAD0100);
        check_val("t1_wren_before_cmpl", wren_pre - s0, 1);

        // Load miss on empty buffer
        s0 = mlr_cyc;
        start_load(16'h0030);
        wait_load("t4");
        check_val("t4_lat", ld_lat, 3);
        check_val("t4_data", ld_data, 32'h00000030);
        check_val("t4_mem_load_req_seen", (mlr_cyc - s0) != 0, 1);
        repeat (3) step();

        // Load hits a buffered block before it drains
        s0 = mlr_cyc;
        do_store("t3", 16'h0028, 32'hBEEF0000, 1);
        start_load(16'h0028);
        wait_load("t3");
        check_val("t3_lat", ld_lat, 1);
        check_val("t3_data", ld_data, 32'hBEEF0000);
        check_val("t3_no_mem_load_req", mlr_cyc - s0, 0);
        wait_empty("t3");

        // Store and load to the same address on the same edge
        store_addr = 16'h0070; store_data = 32'h77770070; store_req = 1'b1;
        start_load(16'h0070);
        step();
        check_val("t7_store_ack", store_ack, 1);
        store_req = 1'b0;
        check_val("t7_lat", ld_lat, 1);
        check_val("t7_data", ld_data, 32'h77770070);
        wait_empty("t7");
        check_val("t7_ram", ram_rd(8'h70), 32'h77770070);

        // Coalescing while drain is blocked by a stalled load miss
        ram_stall = 1'b1;
        start_load(16'h0050);
        do_store("t5a", 16'h0008, 32'h00000001, 1);
        do_store("t5b", 16'h0008, 32'h00000002, 2);
        check_val("t5_full", full, 0);
        check_val("t5_empty", empty, 0);
        s0 = wren_rises;
        ram_stall = 1'b0;
        wait_load("t5");
        check_val("t5_load_data", ld_data, 32'h00000050);
        wait_empty("t5");
        check_val("t5_single_write", wren_rises - s0, 1);
        check_val("t5_ram", ram_rd(8'h08), 32'h00000002);

        // Fill to full, then a fifth store waits for the first pop
        ram_stall = 1'b1;
        start_load(16'h0060);
        for (int i = 0; i < 4; i++)
            do_store("t2_fill", 16'h0010 + 16'(i), 32'hA0000010 + 32'(i), (i == 0) ? 1 : 2);
        check_val("t2_full", full, 1);
        store_addr = 16'h0020; store_data = 32'hB0000020; store_req = 1'b1;
        acked = 1'b0;
        repeat (6) begin
            step();
            if (store_ack) acked = 1'b1;
        end
        check_val("t2_no_ack_while_full", acked, 0);
        check_val("t2_full_held", full, 1);
        ram_stall = 1'b0;
        saw_low = 1'b0;
        for (int i = 0; i < 40 && !store_ack; i++) begin
            step();
            if (!full) saw_low = 1'b1;
        end
        store_req = 1'b0;
        check_val("t2_fifth_ack", store_ack, 1);
        check_val("t2_full_dropped_on_pop", saw_low, 1);
        check_val("t2_full_again", full, 1);
        check_val("t2_load_seen", ld_seen, 1);
        check_val("t2_load_data", ld_data, 32'h00000060);
        wait_empty("t2");
        for (int i = 0; i < 4; i++)
            check_val("t2_ram", ram_rd(8'h10 + 8'(i)), 32'hA0000010 + 32'(i));
        check_val("t2_ram_fifth", ram_rd(8'h20), 32'hB0000020);

        // Reset in the middle of a drain
        do_store("t6", 16'h0040, 32'hC0C0C040, 1);
        for (int i = 0; i < 10 && !mem_wren; i++) step();
        check_val("t6_in_drain", mem_wren, 1);
        rst_n = 1'b0;
        #1;
        check_val("t6_wren_dropped", mem_wren, 0);
        check_val("t6_empty", empty, 1);
        step();
        step();
        rst_n = 1'b1;
        acked = 1'b0;
        saw_low = 1'b0;
        repeat (8) begin
            step();
            if (store_ack) acked = 1'b1;
            if (load_done) saw_low = 1'b1;
        end
        check_val("t6_no_ack_after_rst", acked, 0);
        check_val("t6_no_done_after_rst", saw_low, 0);
        check_val("t6_idle_wren", mem_wren, 0);
        check_val("t6_empty_after", empty, 1);

        check_val("mutex_wren_load_req", excl_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
